// File: rtl/burst_resp_expand.sv
// Write-response expander: pairs each burst-length entry with its single
// memory response and replays that response once per original request.
module burst_resp_expand #(
  parameter int BurstLenWidth = 8,
  parameter int RespWidth     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BurstLenWidth-1:0] burst_len_dout,
  input  logic                     burst_len_empty_n,
  output logic                     burst_len_read,
  input  logic [RespWidth-1:0]     bresp_dout,
  input  logic                     bresp_empty_n,
  output logic                     bresp_read,
  output logic [RespWidth-1:0]     resp_din,
  input  logic                     resp_full_n,
  output logic                     resp_write,
  output logic                     error
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam logic [BurstLenWidth-1:0] One = 1;

  state_t                   state, state_d;
  logic [BurstLenWidth-1:0] remaining, remaining_d;
  logic [RespWidth-1:0]     resp_q, resp_q_d;
  logic                     error_q, error_d;

  logic busy;
  logic take;
  logic wr;
  logic last_emit;

  assign busy      = (state == EMIT);
  assign wr        = busy && resp_full_n && !rst;
  assign last_emit = wr && (remaining == '0);
  assign take      = !rst && burst_len_empty_n && bresp_empty_n
                     && (!busy || last_emit);

  assign burst_len_read = take;
  assign bresp_read     = take;
  assign resp_write     = wr;
  assign resp_din       = resp_q;
  assign error          = error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      resp_q    <= '0;
      error_q   <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= remaining_d;
      resp_q    <= resp_q_d;
      error_q   <= error_d;
    end
  end

  // A pop on the final beat reloads in place so bursts stay contiguous.
  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    resp_q_d    = resp_q;
    error_d     = error_q;
    if (take) begin
      state_d     = EMIT;
      remaining_d = burst_len_dout;
      resp_q_d    = bresp_dout;
      if (bresp_dout != '0) error_d = 1'b1;
    end else if (last_emit) begin
      state_d = IDLE;
    end else if (wr && (remaining != '0)) begin
      remaining_d = remaining - One;
    end
  end

endmodule

// File: tb/tb_burst_resp_expand.sv
// Directed bench for burst_resp_expand: queue-modelled FIFOs,
// per-cycle logs of pops and writes checked against hand-derived values.
module tb_burst_resp_expand;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] burst_len_dout;
  logic       burst_len_empty_n;
  logic       burst_len_read;
  logic [1:0] bresp_dout;
  logic       bresp_empty_n;
  logic       bresp_read;
  logic [1:0] resp_din;
  logic       resp_full_n;
  logic       resp_write;
  logic       error;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_len[$];
  logic [1:0] q_resp[$];
  int         pop_l[$];
  int         pop_b[$];
  int         wr_cyc[$];
  logic [1:0] wr_val[$];
  int         cyc;

  logic       s_rd_l, s_rd_b, s_wr, s_err;
  logic [1:0] s_din;

  burst_resp_expand dut (
    .clk(clk),
    .rst(rst),
    .burst_len_dout(burst_len_dout),
    .burst_len_empty_n(burst_len_empty_n),
    .burst_len_read(burst_len_read),
    .bresp_dout(bresp_dout),
    .bresp_empty_n(bresp_empty_n),
    .bresp_read(bresp_read),
    .resp_din(resp_din),
    .resp_full_n(resp_full_n),
    .resp_write(resp_write),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic f);
    rst               = r;
    resp_full_n       = f;
    burst_len_empty_n = (q_len.size() > 0);
    burst_len_dout    = (q_len.size() > 0) ? q_len[0] : 8'd0;
    bresp_empty_n     = (q_resp.size() > 0);
    bresp_dout        = (q_resp.size() > 0) ? q_resp[0] : 2'd0;
    #1;
    s_rd_l = burst_len_read;
    s_rd_b = bresp_read;
    s_wr   = resp_write;
    s_din  = resp_din;
    s_err  = error;
    @(posedge clk);
    if (s_rd_l === 1'b1) begin
      if (q_len.size() > 0) void'(q_len.pop_front());
      pop_l.push_back(cyc);
    end
    if (s_rd_b === 1'b1) begin
      if (q_resp.size() > 0) void'(q_resp.pop_front());
      pop_b.push_back(cyc);
    end
    if (s_wr === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_val.push_back(s_din);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    pop_l.delete();
    pop_b.delete();
    wr_cyc.delete();
    wr_val.delete();
    cyc = 0;
  endtask

  task automatic do_reset();
    q_len.delete();
    q_resp.delete();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    clear_logs();
  endtask

  initial begin
    int odd_ok;
    int contig;
    rst               = 1'b1;
    resp_full_n       = 1'b1;
    burst_len_empty_n = 1'b0;
    burst_len_dout    = '0;
    bresp_empty_n     = 1'b0;
    bresp_dout        = '0;
    cyc               = 0;
    @(negedge clk);

    // reset state with both FIFOs non-empty
    q_len.push_back(8'd0);
    q_resp.push_back(2'd0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_len_read", s_rd_l, 0);
    chk("rst_bresp_read", s_rd_b, 0);
    chk("rst_write", s_wr, 0);
    chk("rst_error", s_err, 0);
    chk("rst_din", s_din, 0);
    chk("rst_no_log", pop_l.size() + wr_cyc.size(), 0);
    clear_logs();

    // single-beat burst
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk("t1_npop", pop_l.size(), 1);
    chk("t1_pop_cyc", pop_l[0], 0);
    chk("t1_bpop_cyc", pop_b[0], 0);
    chk("t1_nwr", wr_cyc.size(), 1);
    chk("t1_wr_cyc", wr_cyc[0], 1);
    chk("t1_wr_val", wr_val[0], 0);
    chk("t1_err", s_err, 0);

    // error response, 4 beats
    do_reset();
    q_len.push_back(8'd3);
    q_resp.push_back(2'd2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("t2_err_c1", s_err, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    chk("t2_nwr", wr_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_cyc%0d", i), wr_cyc[i], i + 1);
      chk($sformatf("t2_val%0d", i), wr_val[i], 2);
    end
    chk("t2_err_held", s_err, 1);

    // back-to-back bursts
    do_reset();
    q_len.push_back(8'd1);
    q_len.push_back(8'd2);
    q_resp.push_back(2'd0);
    q_resp.push_back(2'd1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
    chk("t3_npop", pop_l.size(), 2);
    chk("t3_nbpop", pop_b.size(), 2);
    chk("t3_pop0", pop_l[0], 0);
    chk("t3_pop1", pop_l[1], 2);
    chk("t3_nwr", wr_cyc.size(), 5);
    begin
      logic [1:0] exp_v[5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("t3_cyc%0d", i), wr_cyc[i], i + 1);
        chk($sformatf("t3_val%0d", i), wr_val[i], exp_v[i]);
      end
    end
    chk("t3_err", s_err, 1);

    // backpressure: resp_full_n high on odd cycles only
    do_reset();
    q_len.push_back(8'd4);
    q_resp.push_back(2'd0);
    for (int i = 0; i < 14; i++) step(1'b0, i[0]);
    chk("t4_nwr", wr_cyc.size(), 5);
    odd_ok = 1;
    foreach (wr_cyc[i]) if (wr_cyc[i] % 2 == 0) odd_ok = 0;
    chk("t4_wr_odd", odd_ok, 1);
    chk("t4_last_wr", wr_cyc[wr_cyc.size()-1], 9);
    chk("t4_npop", pop_l.size() + pop_b.size(), 2);

    // missing response for 10 cycles
    do_reset();
    q_len.push_back(8'd2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("t5_idle_pops", pop_l.size() + pop_b.size(), 0);
    chk("t5_idle_wr", wr_cyc.size(), 0);
    q_resp.push_back(2'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    chk("t5_pop_l", pop_l[0], 10);
    chk("t5_pop_b", pop_b[0], 10);
    chk("t5_nwr", wr_cyc.size(), 3);
    chk("t5_first_wr", wr_cyc[0], 11);
    chk("t5_last_wr", wr_cyc[2], 13);

    // reset after 2 of 8 writes, then a 256-beat burst
    do_reset();
    q_len.push_back(8'd7);
    q_resp.push_back(2'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("t6_pre_wr", wr_cyc.size(), 2);
    q_len.push_back(8'd255);
    q_resp.push_back(2'd0);
    step(1'b1, 1'b1);
    chk("t6_rst_lread", s_rd_l, 0);
    chk("t6_rst_bread", s_rd_b, 0);
    chk("t6_rst_wr", s_wr, 0);
    for (int i = 0; i < 266; i++) step(1'b0, 1'b1);
    chk("t6_npop", pop_l.size(), 2);
    chk("t6_pop1", pop_l[1], 4);
    chk("t6_nwr", wr_cyc.size(), 258);
    chk("t6_first_max", wr_cyc[2], 5);
    contig = 1;
    for (int i = 2; i < wr_cyc.size(); i++)
      if (wr_cyc[i] != i + 3) contig = 0;
    chk("t6_contig", contig, 1);
    chk("t6_err", s_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_resp_expand.md
# burst_resp_expand

Write-response expander for the burst-coalescing memory path. The upstream burst detector merges consecutive per-request addresses into one burst and pushes `burst_len` (beats − 1) into a side FIFO. This block pairs each such entry with the single write response the memory returns for that burst, then emits `burst_len + 1` per-request responses. The requester therefore sees exactly one response per original address.

## Interface

Parameters:
- `BurstLenWidth`, default 8: width of burst-length entries (value = beats − 1).
- `RespWidth`, default 2: width of the memory response code (AXI BRESP encoding; 0 = OKAY).

Ports (clock and reset first):
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `burst_len_dout`  in  BurstLenWidth  head of burst-length FIFO (first-word-fall-through, valid when `burst_len_empty_n`).
- `burst_len_empty_n`  in  1  burst-length FIFO non-empty.
- `burst_len_read`  out  1  pop burst-length FIFO this cycle.
- `bresp_dout`  in  RespWidth  head of memory write-response FIFO.
- `bresp_empty_n`  in  1  response FIFO non-empty.
- `bresp_read`  out  1  pop response FIFO this cycle.
- `resp_din`  out  RespWidth  per-request response to requester.
- `resp_full_n`  in  1  requester response FIFO has space.
- `resp_write`  out  1  push `resp_din` this cycle.
- `error`  out  1  sticky: some popped `bresp_dout` was non-zero.

## Operation

- State register `busy`; counter `remaining` [BurstLenWidth-1:0]; register `resp_q` [RespWidth-1:0]; sticky `error_q`.
- Pop condition `take` = `!rst` && `burst_len_empty_n` && `bresp_empty_n` && (`!busy` || `last_emit`).
- `burst_len_read` = `bresp_read` = `take`. Both FIFOs are always popped together, never one alone.
- `resp_write` = `busy` && `resp_full_n` && `!rst`. `resp_din` = `resp_q`.
- `last_emit` = `resp_write` && (`remaining` == 0).
- On `take`:
  - `remaining` ← `burst_len_dout`.
  - `resp_q` ← `bresp_dout`.
  - `busy` ← 1.
  - if `bresp_dout` != 0, `error_q` ← 1.
- Else on `last_emit`: `busy` ← 0.
- Else on `resp_write`: `remaining` ← `remaining` − 1.
- States:
  - IDLE (`busy`=0): go to EMIT on `take`.
  - EMIT (`busy`=1): each accepted write decrements `remaining`. On the last write, go to IDLE. If `take` fires in that same cycle, stay in EMIT and reload `remaining`/`resp_q` (no bubble).
- Arithmetic: `remaining` never wraps. A decrement happens only when `remaining` > 0. `burst_len_dout` = all-ones yields 2^BurstLenWidth responses.
- `error` = `error_q`. It is cleared only by reset.
- Ordering: responses leave in burst-FIFO order. The block assumes the memory returns responses in issue order.

## Timing

- Reset values: `busy`=0, `remaining`=0, `resp_q`=0, `error_q`=0.
- While `rst`=1, `burst_len_read`=0, `bresp_read`=0 and `resp_write`=0, regardless of inputs.
- Latency: pop at cycle N → first `resp_write` at cycle N+1 at the earliest.
- Throughput: with `resp_full_n`=1 throughout, a burst of length L occupies exactly L+1 consecutive write cycles. Back-to-back bursts are contiguous.
- Backpressure: `resp_full_n`=0 stalls emission. `remaining` and `resp_q` hold, and no pop occurs unless already IDLE.
- One FIFO non-empty while the other is empty: no pop and no state change.
- Reset asserted mid-burst: the remaining responses are discarded, and the block returns to IDLE on the next edge.

## Test plan

- **Single-beat burst.** `burst_len`=0, `bresp`=0 queued at cycle 0. Required: pop at cycle 0; exactly one `resp_write` with `resp_din`=0 at cycle 1; `error`=0.
- **Error response.** `burst_len`=3, `bresp`=2. Required: 4 consecutive writes with `resp_din`=2; `error`=1 from cycle 1 onward and held after the burst.
- **Back-to-back bursts.** Lengths 1 then 2 queued, responses 0 then 1, `resp_full_n`=1. Required: pops at cycles 0 and 2; 5 contiguous writes in cycles 1–5 carrying 0,0,1,1,1.
- **Backpressure.** `burst_len`=4, `resp_full_n` alternating 1/0. Required: exactly 5 writes, each only in a cycle with `resp_full_n`=1; no extra pop.
- **Missing response.** `burst_len`=2 present, `bresp` FIFO empty for 10 cycles. Required: no reads and no writes during those cycles; on arrival, pop both FIFOs, then 3 writes.
- **Reset mid-burst and maximum length.**
  - Reset after 2 of 8 writes: no further writes; `error`=0; reads held at 0 during reset.
  - Then `burst_len`=255: exactly 256 writes.
